// File: rtl/uart_apb_fifo_regs.sv
// APB register front end for the UART: TX/RX FIFOs, baud/control registers,
// status with sticky W1C error flags, FIFO levels and a registered interrupt.
`timescale 1ns/1ps

module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       pClk,
    input  logic                       pReset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wrData,
    output logic [WIDTH-1:0]           rdData,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign rdData = mem[rdPtr];
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign doPush = push && (!full || pop);
    assign doPop  = pop && !empty;

    always_ff @(posedge pClk) begin
        if (doPush && !flush) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PW'(1);
            if (doPop)  rdPtr <= rdPtr + PW'(1);
            if (doPush && !doPop) begin
                count <= count + CW'(1);
            end else if (doPop && !doPush) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

module uart_apb_fifo_regs #(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int BAUD_W   = 16,
    parameter int BAUD_RST = 325
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              pSel,
    input  logic              pEnable,
    input  logic              pWrite,
    input  logic [31:0]       pAddr,
    input  logic [31:0]       pWdata,
    output logic [31:0]       pReadData,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              rx_frm_err,
    output logic [BAUD_W-1:0] baud_div,
    output logic              tx_en,
    output logic              rx_en,
    output logic              irq
);
    typedef enum logic [7:0] {
        REG_TXDATA = 8'h00,
        REG_RXDATA = 8'h01,
        REG_BAUD   = 8'h02,
        REG_CTRL   = 8'h03,
        REG_STATUS = 8'h04,
        REG_LEVEL  = 8'h05
    } regAddr_e;

    logic [7:0]  addr;
    logic        wrAccess;
    logic        rdAccess;
    logic        rdSetup;
    logic [4:0]  ctrlReg;
    logic        rxOvf, txOvf, frmErr;
    logic [2:0]  stickyClr;
    logic [7:0]  status;
    logic [31:0] rdMux;
    logic        unusedBits;

    logic                      txPushReq, txPopReq, txFlush, txEmpty, txFull;
    logic                      rxPushReq, rxPopReq, rxFlush, rxEmpty, rxFull;
    logic [$clog2(TX_DEPTH):0] txCount;
    logic [$clog2(RX_DEPTH):0] rxCount;
    logic [DATA_W-1:0]         rxHead;

    assign addr       = pAddr[7:0];
    assign wrAccess   = pSel && pEnable && pWrite;
    assign rdAccess   = pSel && pEnable && !pWrite;
    assign rdSetup    = pSel && !pEnable && !pWrite;
    assign unusedBits = ^{pAddr[31:8], pWdata};

    assign tx_en    = ctrlReg[0];
    assign rx_en    = ctrlReg[1];
    assign tx_valid = !txEmpty && tx_en;

    assign txPushReq = wrAccess && (addr == REG_TXDATA);
    assign txPopReq  = tx_valid && tx_ready;
    assign txFlush   = wrAccess && (addr == REG_CTRL) && pWdata[5];
    assign rxPushReq = rx_valid && rx_en;
    assign rxPopReq  = rdAccess && (addr == REG_RXDATA);
    assign rxFlush   = wrAccess && (addr == REG_CTRL) && pWdata[6];
    assign stickyClr = (wrAccess && (addr == REG_STATUS)) ? pWdata[7:5] : '0;

    uart_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) txFifo (
        .pClk(pClk), .pReset(pReset), .flush(txFlush), .push(txPushReq),
        .pop(txPopReq), .wrData(pWdata[DATA_W-1:0]), .rdData(tx_data),
        .count(txCount), .empty(txEmpty), .full(txFull)
    );

    uart_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) rxFifo (
        .pClk(pClk), .pReset(pReset), .flush(rxFlush), .push(rxPushReq),
        .pop(rxPopReq), .wrData(rx_data), .rdData(rxHead),
        .count(rxCount), .empty(rxEmpty), .full(rxFull)
    );

    assign status = {frmErr, txOvf, rxOvf, rxFull, txFull, !txFull, txEmpty, !rxEmpty};

    always_comb begin
        rdMux = '0;
        case (addr)
            REG_RXDATA: rdMux[DATA_W-1:0] = rxEmpty ? '0 : rxHead;
            REG_BAUD:   rdMux[BAUD_W-1:0] = baud_div;
            REG_CTRL:   rdMux[4:0]        = ctrlReg;
            REG_STATUS: rdMux[7:0]        = status;
            REG_LEVEL:  rdMux[15:0]       = {8'(rxCount), 8'(txCount)};
            default:    rdMux             = '0;
        endcase
    end

    // Overflow is suppressed when a flush lands in the same cycle; a new
    // error event beats a simultaneous W1C of the same bit.
    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            pReadData <= '0;
            ctrlReg   <= '0;
            baud_div  <= BAUD_W'(BAUD_RST);
            rxOvf     <= 1'b0;
            txOvf     <= 1'b0;
            frmErr    <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (rdSetup) pReadData <= rdMux;
            if (wrAccess && (addr == REG_CTRL)) ctrlReg  <= pWdata[4:0];
            if (wrAccess && (addr == REG_BAUD)) baud_div <= pWdata[BAUD_W-1:0];
            rxOvf  <= (rxPushReq && rxFull && !rxPopReq && !rxFlush) || (rxOvf && !stickyClr[0]);
            txOvf  <= (txPushReq && txFull && !txPopReq && !txFlush) || (txOvf && !stickyClr[1]);
            frmErr <= rx_frm_err || (frmErr && !stickyClr[2]);
            irq    <= (ctrlReg[2] && !rxEmpty) || (ctrlReg[3] && txEmpty)
                   || (ctrlReg[4] && (rxOvf || txOvf || frmErr));
        end
    end
endmodule
